// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array and its edge feeders.
package systolic_pkg;

  localparam int DATA_W = 32;
  localparam int SUM_W  = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

  // Cycles of zero injection needed for the last partial sum to exit the bottom row.
  function automatic int drain_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/act_skew_feeder_if.sv
// Upstream vector handshake plus the array-facing outputs of the activation feeder.
interface act_skew_feeder_if #(
  parameter int ROWS   = 4,
  parameter int DATA_W = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [ROWS*DATA_W-1:0]   in_vec;
  logic                     in_last;
  logic [ROWS*DATA_W-1:0]   act_out;
  logic                     array_en;
  logic                     busy;
  logic                     done;

  modport master (
    output in_valid, in_vec, in_last,
    input  in_ready, act_out, array_en, busy, done
  );

  modport slave (
    input  in_valid, in_vec, in_last,
    output in_ready, act_out, array_en, busy, done
  );
endinterface

// File: rtl/skew_delay_line.sv
// One lane of the diagonal skew: a DEPTH-stage shift register that only moves on adv.
module skew_delay_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              adv,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] stage_reg [DEPTH];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stage_reg[0] <= '0;
    end else if (clr) begin
      stage_reg[0] <= '0;
    end else if (adv) begin
      stage_reg[0] <= din;
    end
  end

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        stage_reg[gi] <= '0;
      end else if (clr) begin
        stage_reg[gi] <= '0;
      end else if (adv) begin
        stage_reg[gi] <= stage_reg[gi-1];
      end
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// Left-edge activation feeder: accepts vectors, skews row r by r+1 advances,
// drives the array-wide enable and drains the array with zeros after the last beat.
module act_skew_feeder #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = systolic_pkg::DATA_W
) (
  input  logic               CLK,
  input  logic               RESET,
  act_skew_feeder_if.slave   bus
);
  import systolic_pkg::*;

  localparam int DRAIN_LEN = drain_len(ROWS, COLS);
  localparam int CNT_W     = $clog2(ROWS + COLS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_LEN - 1);

  feeder_state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic adv;
  logic clr;
  logic ready;
  logic load_zero;
  logic array_en_reg;
  logic done_reg;
  logic [ROWS-1:0][DATA_W-1:0] lane_out;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      array_en_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      array_en_reg <= adv;
      done_reg     <= (state_reg == DONE);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    adv        = 1'b0;
    clr        = 1'b0;
    ready      = 1'b0;
    case (state_reg)
      IDLE, STREAM: begin
        ready = 1'b1;
        adv   = bus.in_valid;
        if (bus.in_valid) begin
          cnt_next   = '0;
          state_next = bus.in_last ? DRAIN : STREAM;
        end
      end
      DRAIN: begin
        adv = 1'b1;
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        // Guarantees zero fill for the next tile even if a line was never fully flushed.
        clr        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign load_zero = (state_reg == DRAIN);

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_lane
    logic [DATA_W-1:0] lane_in;
    assign lane_in = load_zero ? '0 : bus.in_vec[gi*DATA_W +: DATA_W];

    skew_delay_line #(
      .DEPTH  (gi + 1),
      .DATA_W (DATA_W)
    ) u_line (
      .CLK   (CLK),
      .RESET (RESET),
      .adv   (adv),
      .clr   (clr),
      .din   (lane_in),
      .dout  (lane_out[gi])
    );
  end

  assign bus.act_out  = lane_out;
  assign bus.in_ready = ready;
  assign bus.array_en = array_en_reg;
  assign bus.done     = done_reg;
  assign bus.busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed bench for act_skew_feeder (ROWS=COLS=4): table-driven tile plus hand sequences.
module tb_act_skew_feeder;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 32;
  localparam int VW   = ROWS * DW;

  logic clk;
  logic rst_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  act_skew_feeder_if #(.ROWS(ROWS), .DATA_W(DW)) bus();

  act_skew_feeder #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          vld;
    logic          last;
    logic [VW-1:0] vec;
    logic [VW-1:0] e_act;
    logic          e_en;
    logic          e_done;
    logic          e_ready;
    logic          e_busy;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [VW-1:0] v4(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic last, input logic [VW-1:0] vec);
    bus.in_valid = vld;
    bus.in_last  = last;
    bus.in_vec   = vec;
  endtask

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic exp_cyc(input string tag, input logic [VW-1:0] e_act, input logic e_en,
                         input logic e_done, input logic e_ready, input logic e_busy);
    chk({tag, ".act_out"},  bus.act_out,  e_act);
    chk({tag, ".array_en"}, VW'(bus.array_en), VW'(e_en));
    chk({tag, ".done"},     VW'(bus.done),     VW'(e_done));
    chk({tag, ".in_ready"}, VW'(bus.in_ready), VW'(e_ready));
    chk({tag, ".busy"},     VW'(bus.busy),     VW'(e_busy));
  endtask

  // Single-beat tile: lane r shows its value only on cycle r+1, done on cycle 9.
  task automatic single_tile(input string tag, input logic [VW-1:0] vec);
    logic [VW-1:0] e;
    drive(1'b1, 1'b1, vec);
    tick();
    drive(1'b0, 1'b0, '0);
    for (int c = 1; c <= 9; c++) begin
      e = '0;
      if (c <= ROWS) e[(c-1)*DW +: DW] = vec[(c-1)*DW +: DW];
      if (c <= 8) exp_cyc($sformatf("%s c%0d", tag, c), e, 1'b1, 1'b0, 1'b0, 1'b1);
      else        exp_cyc($sformatf("%s c%0d", tag, c), e, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Three-beat tile, continuous valid, hand-computed per cycle
    tbl[0]  = '{1'b1, 1'b0, v4(1,2,3,4),    v4(0,0,0,0),   1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, v4(5,6,7,8),    v4(1,0,0,0),   1'b1, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, v4(9,10,11,12), v4(5,2,0,0),   1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, v4(0,0,0,0),    v4(9,6,3,0),   1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, v4(0,0,0,0),    v4(0,10,7,4),  1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, v4(0,0,0,0),    v4(0,0,11,8),  1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, v4(0,0,0,0),    v4(0,0,0,12),  1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, v4(0,0,0,0),    v4(0,0,0,0),   1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, v4(0,0,0,0),    v4(0,0,0,0),   1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, v4(0,0,0,0),    v4(0,0,0,0),   1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, v4(0,0,0,0),    v4(0,0,0,0),   1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, v4(0,0,0,0),    v4(0,0,0,0),   1'b0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, v4(0,0,0,0),    v4(0,0,0,0),   1'b0, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    exp_cyc("reset", '0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      exp_cyc($sformatf("tile3 c%0d", i), tbl[i].e_act, tbl[i].e_en, tbl[i].e_done,
              tbl[i].e_ready, tbl[i].e_busy);
      drive(tbl[i].vld, tbl[i].last, tbl[i].vec);
      tick();
    end

    // Stall for two cycles after beat 1; X on in_vec while invalid must not leak
    drive(1'b1, 1'b0, v4(1,2,3,4));
    tick();
    exp_cyc("stall c1", v4(1,0,0,0), 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 'x);
    tick();
    exp_cyc("stall c2", v4(1,0,0,0), 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    exp_cyc("stall c3", v4(1,0,0,0), 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, v4(5,6,7,8));
    tick();
    exp_cyc("stall c4", v4(5,2,0,0), 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, v4(9,10,11,12));
    tick();
    exp_cyc("stall c5", v4(9,6,3,0), 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, '0);
    tick();
    exp_cyc("stall c6", v4(0,10,7,4), 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    exp_cyc("stall c7", v4(0,0,11,8), 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    exp_cyc("stall c8", v4(0,0,0,12), 1'b1, 1'b0, 1'b0, 1'b1);
    for (int c = 9; c <= 12; c++) begin
      tick();
      exp_cyc($sformatf("stall c%0d", c), '0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    tick();
    exp_cyc("stall c13", '0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();

    single_tile("single7", v4(7,7,7,7));

    // Backpressure: valid stays high with junk through DRAIN/DONE
    drive(1'b1, 1'b1, v4(1,2,3,4));
    tick();
    for (int c = 1; c <= 8; c++) begin
      logic [VW-1:0] e;
      e = '0;
      if (c <= ROWS) e[(c-1)*DW +: DW] = 32'(c);
      drive(1'b1, 1'b0, v4(32'hAA, 32'hAB, 32'hAC, 32'hAD));
      exp_cyc($sformatf("bp c%0d", c), e, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
    end
    exp_cyc("bp c9", '0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, v4(32'h11, 32'h12, 32'h13, 32'h14));
    tick();
    exp_cyc("bp c10", v4(32'h11,0,0,0), 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, '0);
    for (int c = 11; c <= 18; c++) begin
      tick();
      chk($sformatf("bp c%0d.done", c), VW'(bus.done), VW'(c == 18));
    end
    tick();

    // Asynchronous reset in the third DRAIN cycle
    drive(1'b1, 1'b0, v4(1,2,3,4));   tick();
    drive(1'b1, 1'b0, v4(5,6,7,8));   tick();
    drive(1'b1, 1'b1, v4(9,10,11,12)); tick();
    drive(1'b0, 1'b0, '0);            tick();
    tick();
    exp_cyc("prerst c5", v4(0,0,11,8), 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cyc("rst async", '0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      exp_cyc($sformatf("postrst c%0d", c), '0, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    single_tile("after_rst", v4(32'h21, 32'h22, 32'h23, 32'h24));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
